// File: rtl/key_event.sv
// key_event: front-panel key-event decoder for one pushbutton.
// Synchronises and debounces an active-low raw key, then times each press to
// emit one-cycle short_press / long_press pulses and, when the build defines
// KEY_EVENT_REPEAT_EN, periodic repeat_pulse pulses while a long press is held.
// With KEY_EVENT_REPEAT_EN undefined the repeat counter is absent and
// repeat_pulse is tied low.
module key_event #(
    parameter int DEBOUNCE  = 10000000,
    parameter int LONG_HOLD = 50000000,
    parameter int REPEAT    = 10000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button,
    output logic short_press,
    output logic long_press,
    output logic repeat_pulse,
    output logic held
);

    // Terminal counts; each counter stops here, so none can ever wrap.
    localparam logic [31:0] DB_LAST   = 32'(DEBOUNCE - 1);
    localparam logic [31:0] HOLD_LAST = 32'(LONG_HOLD - 1);

    // Catch illegal parameterisations at elaboration.
    if (DEBOUNCE < 1 || LONG_HOLD < 1 || REPEAT < 1) begin : g_param_check
        $error("key_event: DEBOUNCE, LONG_HOLD and REPEAT must all be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } state_t;

    logic        sync1;
    logic        sync2;
    logic        db;
    logic [31:0] cnt_db;
    logic [31:0] cnt_hold;
    state_t      state;

    // Two-flop synchroniser for the asynchronous key; idles at "released".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
        end
    end

    // Debounce: db follows sync2 only after DEBOUNCE consecutive differing cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db     <= 1'b1;
            cnt_db <= 32'd0;
        end else if (sync2 == db) begin
            cnt_db <= 32'd0;
        end else if (cnt_db == DB_LAST) begin
            db     <= sync2;
            cnt_db <= 32'd0;
        end else begin
            cnt_db <= cnt_db + 32'd1;
        end
    end

`ifdef KEY_EVENT_REPEAT_EN
    localparam logic [31:0] REP_LAST = 32'(REPEAT - 1);
    logic [31:0] cnt_rep;
`else
    // No auto-repeat in this build: the port stays but never pulses.
    assign repeat_pulse = 1'b0;
`endif

    // Press-timing FSM with registered pulse outputs and held level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt_hold    <= 32'd0;
            short_press <= 1'b0;
            long_press  <= 1'b0;
            held        <= 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
            cnt_rep      <= 32'd0;
            repeat_pulse <= 1'b0;
`endif
        end else begin
            short_press <= 1'b0;
            long_press  <= 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
            repeat_pulse <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!db) begin
                        state    <= PRESSED;
                        cnt_hold <= 32'd0;
                        held     <= 1'b1;
                    end
                end
                PRESSED: begin
                    // Release is tested first so it wins over a coincident hold expiry.
                    if (db) begin
                        short_press <= 1'b1;
                        state       <= IDLE;
                        held        <= 1'b0;
                    end else if (cnt_hold == HOLD_LAST) begin
                        long_press <= 1'b1;
                        state      <= LONG;
`ifdef KEY_EVENT_REPEAT_EN
                        cnt_rep    <= 32'd0;
`endif
                    end else begin
                        cnt_hold <= cnt_hold + 32'd1;
                    end
                end
                LONG: begin
                    if (db) begin
                        state <= IDLE;
                        held  <= 1'b0;
                    end
`ifdef KEY_EVENT_REPEAT_EN
                    else if (cnt_rep == REP_LAST) begin
                        repeat_pulse <= 1'b1;
                        cnt_rep      <= 32'd0;
                    end else begin
                        cnt_rep <= cnt_rep + 32'd1;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                    held  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_event.sv
// tb_key_event: table-driven press scenarios with an event scoreboard for
// key_event (DEBOUNCE=4, LONG_HOLD=20, REPEAT=5). Expected events carry the
// edge number, counted from the first edge that samples button=0.
// Repeat expectations follow KEY_EVENT_REPEAT_EN.
module tb_key_event;

    localparam int DEB  = 4;
    localparam int HOLD = 20;
    localparam int REP  = 5;

    localparam int K_SHORT = 0;
    localparam int K_LONG  = 1;
    localparam int K_REP   = 2;
    localparam int K_RISE  = 3;
    localparam int K_FALL  = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic button;
    logic short_press;
    logic long_press;
    logic repeat_pulse;
    logic held;

    int checks = 0;
    int errors = 0;
    logic prev_held = 1'b0;

    typedef struct {
        int kind;
        int edge_n;
    } ev_t;

    ev_t sb[$];

    // low = button-low cycles (edges 0..low-1); -1 means event not expected
    typedef struct {
        string name;
        int    low;
        int    rise;
        int    long_e;
        int    short_e;
        int    fall;
    } vec_t;

    vec_t vecs[6];

    key_event #(
        .DEBOUNCE (DEB),
        .LONG_HOLD(HOLD),
        .REPEAT   (REP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .button      (button),
        .short_press (short_press),
        .long_press  (long_press),
        .repeat_pulse(repeat_pulse),
        .held        (held)
    );

    always #5 clk = ~clk;

    function automatic string kname(input int k);
        case (k)
            K_SHORT: return "short_press";
            K_LONG:  return "long_press";
            K_REP:   return "repeat_pulse";
            K_RISE:  return "held_rise";
            K_FALL:  return "held_fall";
            default: return "unknown";
        endcase
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic push(input int kind, input int e);
        ev_t ev;
        ev.kind   = kind;
        ev.edge_n = e;
        sb.push_back(ev);
    endtask

    // Compare one observed DUT event against the scoreboard head.
    task automatic observe(input int kind, input int e);
        ev_t ev;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got %s at edge %0d, expected none", kname(kind), e);
        end else begin
            ev = sb.pop_front();
            if (ev.kind != kind || ev.edge_n != e) begin
                errors++;
                $display("FAIL event_order: got %s at edge %0d, expected %s at edge %0d",
                         kname(kind), e, kname(ev.kind), ev.edge_n);
            end else begin
                $display("event %s at edge %0d ok", kname(kind), e);
            end
        end
    endtask

    // Sample outputs after edge e and feed any events to the scoreboard.
    task automatic sample(input int e);
        int n;
        n = int'(short_press) + int'(long_press) + int'(repeat_pulse);
        checks++;
        if (n > 1) begin
            errors++;
            $display("FAIL pulse_exclusive: got %0d pulses at edge %0d, expected at most 1", n, e);
        end
        if (short_press)       observe(K_SHORT, e);
        if (long_press)        observe(K_LONG, e);
        if (repeat_pulse)      observe(K_REP, e);
        if (held && !prev_held) observe(K_RISE, e);
        if (!held && prev_held) observe(K_FALL, e);
        prev_held = held;
    endtask

    task automatic drain(input string name);
        ev_t ev;
        chk({name, "_pending"}, sb.size(), 0);
        while (sb.size() > 0) begin
            ev = sb.pop_front();
            $display("  missing %s at edge %0d", kname(ev.kind), ev.edge_n);
        end
    endtask

    task automatic push_repeats(input int long_e, input int fall);
`ifdef KEY_EVENT_REPEAT_EN
        for (int r = long_e + REP; r < fall; r += REP) push(K_REP, r);
`endif
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_short"},  int'(short_press),  0);
        chk({name, "_long"},   int'(long_press),   0);
        chk({name, "_repeat"}, int'(repeat_pulse), 0);
        chk({name, "_held"},   int'(held),         0);
    endtask

    initial begin
        vecs[0] = '{"glitch",     3,  -1, -1, -1, -1};
        vecs[1] = '{"min_press",  4,   6, -1, 10, 10};
        vecs[2] = '{"short",      10,  6, -1, 16, 16};
        vecs[3] = '{"boundary",   20,  6, -1, 26, 26};
        vecs[4] = '{"just_long",  21,  6, 26, -1, 27};
        vecs[5] = '{"long",       60,  6, 26, -1, 66};

        // Reset state
        rst_n  = 1'b0;
        button = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Table-driven press scenarios
        for (int v = 0; v < 6; v++) begin
            $display("scenario %s low=%0d", vecs[v].name, vecs[v].low);
            if (vecs[v].rise >= 0)    push(K_RISE, vecs[v].rise);
            if (vecs[v].long_e >= 0) begin
                push(K_LONG, vecs[v].long_e);
                push_repeats(vecs[v].long_e, vecs[v].fall);
            end
            if (vecs[v].short_e >= 0) push(K_SHORT, vecs[v].short_e);
            if (vecs[v].fall >= 0)    push(K_FALL, vecs[v].fall);
            for (int e = 0; e < vecs[v].low + 20; e++) begin
                button = (e < vecs[v].low) ? 1'b0 : 1'b1;
                @(posedge clk);
                #1;
                sample(e);
            end
            drain(vecs[v].name);
        end

        // Reset mid-hold: press, reset at edge 15..16, key still held after
        $display("scenario reset_mid_hold");
        push(K_RISE, 6);
        for (int e = 0; e < 15; e++) begin
            button = 1'b0;
            @(posedge clk);
            #1;
            sample(e);
        end
        chk("midhold_held_before_reset", int'(held), 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midhold_async");
        for (int e = 15; e < 17; e++) begin
            @(posedge clk);
            #1;
            chk_all_zero("midhold_in_reset");
        end
        rst_n     = 1'b1;
        prev_held = 1'b0;
        push(K_RISE, 23);
        push(K_LONG, 43);
        push_repeats(43, 56);
        push(K_FALL, 56);
        for (int e = 17; e < 76; e++) begin
            button = (e <= 49) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
            sample(e);
        end
        drain("reset_mid_hold");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
